// File: rtl/disp_trace_multi_if.sv
// disp_trace_multi_if: framebuffer arbiter write port
interface arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 16
);
   logic          req;
   logic          ack;
   logic          wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   modport master (output req, addr, data, wr, input ack);
   modport slave  (input req, addr, data, wr, output ack);
endinterface

// File: rtl/disp_trace_multi.sv
// disp_trace_multi: renders enabled sample channels as dot or Bresenham polyline traces into the framebuffer
module disp_trace_multi #(
   parameter int CH   = 4,
   parameter int SW   = 10,
   parameter int SIZE = 64,
   parameter int W    = 320,
   parameter int H    = 240,
   parameter int BASE = 0,
   parameter int SWAP = 'h20000
) (
   input  logic                                clkSYS,
   input  logic                                n_reset,
   input  logic                                start,
   output logic                                done,
   input  logic                                stat,
   input  logic                                mode,
   input  logic [CH-1:0]                       ch_en,
   input  logic [CH*16-1:0]                    colour,
   output logic [(CH > 1 ? $clog2(CH) : 1)-1:0] smpl_ch,
   output logic                                smpl_ready,
   input  logic                                smpl_valid,
   input  logic [SW-1:0]                       smpl,
   arbiter_if.master                           arb
);
   localparam int CHW   = CH > 1 ? $clog2(CH) : 1;
   localparam int XW    = $clog2(W);
   localparam int YW    = $clog2(H);
   localparam int IW    = $clog2(SIZE + 1);
   localparam int PW    = SW + YW + 1;
   localparam int EW    = (XW > YW ? XW : YW) + 3;
   localparam int XSTEP = (W - 1) / (SIZE - 1);

   typedef enum logic [2:0] {IDLE, SEEK, FETCH, PLOT, FIN} state_t;

   state_t                state, state_n;
   logic [CH-1:0]         pend;
   logic                  mode_q, stat_q;
   logic [IW-1:0]         idx;
   logic [XW-1:0]         px, tx, x_n;
   logic [YW-1:0]         py, ty, y_n, dy_abs;
   logic                  sy;
   logic signed [EW-1:0]  dx, dy, err, e2, dx_n, dy_n;
   logic [PW-1:0]         prod;
   logic [CHW-1:0]        sel;
   logic                  req_q;
   logic [31:0]           addr_q, pix, base;
   logic [15:0]           data_q;
   logic                  accept, at_end, step_x, step_y, last;

   assign smpl_ready = state == FETCH;
   assign accept     = smpl_ready && smpl_valid;
   assign prod       = PW'(smpl) * PW'(H);
   assign y_n        = YW'(PW'(H - 1) - (prod >> SW));
   assign x_n        = idx == '0 ? '0 : px + XW'(XSTEP);
   assign dy_abs     = y_n >= py ? y_n - py : py - y_n;
   assign dx_n       = EW'(x_n) - EW'(px);
   assign dy_n       = EW'(0) - EW'(dy_abs);
   assign e2         = err <<< 1;
   assign step_x     = e2 >= dy;
   assign step_y     = e2 <= dx;
   assign at_end     = px == tx && py == ty;
   assign last       = idx == IW'(SIZE);
   assign pix        = 32'(py) * 32'(W) + 32'(px);
   assign base       = stat_q ? 32'(SWAP) : 32'(BASE);
   assign arb.req    = req_q;
   assign arb.addr   = addr_q;
   assign arb.data   = data_q;
   assign arb.wr     = 1'b1;

   // lowest still-pending channel wins
   always_comb begin
      sel = '0;
      for (int i = CH - 1; i >= 0; i--) if (pend[i]) sel = CHW'(i);
   end

   // state register
   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) state <= IDLE;
      else state <= state_n;
   end

   // next-state: line mode sample 0 only seeds the previous point, so it loops back to fetch
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? SEEK : IDLE;
         SEEK:    state_n = pend == '0 ? FIN : FETCH;
         FETCH:   if (accept) state_n = (!mode_q && idx == '0) ? FETCH : PLOT;
         PLOT:    if (req_q && arb.ack && at_end) state_n = last ? SEEK : FETCH;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // datapath: frame latches, sample conversion, Bresenham stepping and the write handshake
   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         pend    <= '0;
         mode_q  <= 1'b0;
         stat_q  <= 1'b0;
         idx     <= '0;
         px      <= '0;
         py      <= '0;
         tx      <= '0;
         ty      <= '0;
         sy      <= 1'b0;
         dx      <= '0;
         dy      <= '0;
         err     <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         smpl_ch <= '0;
         done    <= 1'b0;
      end else begin
         done <= state_n == FIN;
         case (state)
            IDLE: if (start) begin
               pend   <= ch_en;
               mode_q <= mode;
               stat_q <= stat;
            end
            SEEK: if (pend != '0) begin
               smpl_ch   <= sel;
               pend[sel] <= 1'b0;
               idx       <= '0;
            end
            FETCH: if (accept) begin
               idx <= idx + IW'(1);
               tx  <= x_n;
               ty  <= y_n;
               dx  <= dx_n;
               dy  <= dy_n;
               err <= dx_n + dy_n;
               sy  <= y_n >= py;
               if (mode_q || idx == '0) begin
                  px <= x_n;
                  py <= y_n;
               end
            end
            PLOT: if (!req_q) begin
               req_q  <= 1'b1;
               addr_q <= base | pix;
               data_q <= colour[32'(smpl_ch) * 16 +: 16];
            end else if (arb.ack) begin
               req_q <= 1'b0;
               if (!at_end) begin
                  err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
                  px  <= px + XW'(step_x);
                  py  <= sy ? py + YW'(step_y) : py - YW'(step_y);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/disp_trace_multi.md
Name: disp_trace_multi

Overview:
- Renders up to CH sample channels as polyline or dot traces into the display framebuffer, one enabled channel after another.
- Consumes a same-clock sample stream, converts each sample to screen coordinates and rasterises with an internal Bresenham engine.
- Writes pixels through the system arbiter.
- Successor to the single-channel sparse renderer: adds channel count, enable mask, per-channel colour, sample width and a dot/line mode.

Parameters:
- CH, 4, number of channels (1..8)
- SW, 10, sample width in bits
- SIZE, 64, samples per channel per frame (>=2)
- W, 320, screen width in pixels
- H, 240, screen height in pixels
- BASE, 0, framebuffer base address, buffer 0
- SWAP, 'h20000, framebuffer base address, buffer 1

Ports:
- clkSYS  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame
- done  out  1  one-cycle pulse when the frame is complete
- stat  in  1  render buffer select: 1=SWAP, 0=BASE
- mode  in  1  0=line, 1=dot; sampled at start
- ch_en  in  CH  channel enable mask; sampled at start
- colour  in  CH*16  RGB565 colour per channel; channel c uses bits [16c+15:16c]
- smpl_ch  out  $clog2(CH) (min 1)  channel currently requested
- smpl_ready  out  1  block accepts smpl this cycle
- smpl_valid  in  1  smpl is valid
- smpl  in  SW  sample value, 0 = bottom of screen
- arb  interface  -  arbiter_if master (req, ack, addr, data, wr)

Behaviour:
- Reset values: done=0, smpl_ready=0, smpl_ch=0, arb.req=0, arb.addr=0, arb.data=0, state=Idle. arb.wr is tied to 1.
- States:
  - Idle: on start, latch ch_en, mode and stat; go to Seek.
  - Seek: select the lowest enabled channel not yet drawn. If none remain, go to Fin.
  - Fetch: assert smpl_ready. A sample transfers on smpl_valid && smpl_ready.
  - Plot: drive pixel writes until the segment or point is done, then return to Fetch. After the SIZE-th sample's pixels, go to Seek.
  - Fin: pulse done for one cycle, then go to Idle.
- start is ignored outside Idle.
- If ch_en==0 at start: done pulses exactly 2 cycles after start.
- Coordinate conversion:
  - y = (H-1) - ((smpl*H) >> SW), computed at full product width and truncated to $clog2(H) bits.
  - Result is always in [0, H-1].
- x position:
  - x = 0 for sample 0 of each channel.
  - x increments by XSTEP = (W-1)/(SIZE-1) (integer division) per sample.
  - No wrap is possible by construction.
- Line mode:
  - Sample 0 only loads the previous point; it produces no writes.
  - Each subsequent sample draws the Bresenham segment from the previous point to the new point, including both endpoints.
  - Shared endpoints are written twice. That is permitted.
- Dot mode: every sample writes exactly one pixel at (x, y).
- Write handshake:
  - arb.req rises together with stable arb.addr and arb.data.
  - arb.req holds until arb.ack is sampled high.
  - req drops in the cycle after ack. The next pixel may assert req in the following cycle (one write per ack).
  - addr = (stat_latched ? SWAP : BASE) | (y*W + x).
  - data = colour of the current channel.
- smpl_ready is low whenever state != Fetch. The upstream source must hold smpl_valid and smpl stable while waiting.
- smpl_ch is valid from Seek through the last Plot of that channel.
- Changes to ch_en, mode, stat or colour mid-frame do not affect the current frame.
  - Exception: colour is used live; software must hold it for the frame.
- Reset mid-frame: immediate return to Idle with all outputs at reset values. No done pulse.
- Simultaneous start and done: impossible, since done occurs only in Fin.

Test Plan:
1. W=320, H=240, SIZE=5, SW=10, CH=1, ch_en=1, mode=1, samples 0,1023,512,0,256 -> exactly 5 writes.
   - Addresses at y*320+x: (0,239), (79,0), (158,119), (237,239), (316,179).
   - done pulses once after the 5th ack.
2. Same config, mode=0, samples 512,512,512,512,512 -> 4 horizontal segments, 80 pixels each, 320 writes total. All at y=119; x spans 0..316.
3. CH=4, ch_en=4'b1010, mode=1, stat=1 -> smpl_ch shows 1 then 3, 2*SIZE samples consumed, all addresses OR'd with SWAP, data equals colour[31:16] then colour[63:48].
4. ch_en=0, start -> no smpl_ready, no arb.req, done pulses 2 cycles after start.
5. arb.ack delayed randomly 0..7 cycles and smpl_valid throttled 50% -> identical address/data write sequence to scenario 2. req never drops before ack; addr/data stable while req is high.
6. n_reset low during the middle of scenario 2, then release -> all outputs 0, no done. A new start renders the full frame correctly.
